// File: rtl/sr_latch_drv_if.sv
// Request/status bundle between a latch-write client and sr_latch_drv.
// The master side issues one-shot set/reset requests and supplies latch Q feedback.
interface sr_latch_drv_if;
  logic set_req;
  logic rst_req;
  logic q_fb;
  logic S;
  logic R;
  logic busy;
  logic done;
  logic last_op;
  logic err;

  modport master (
    output set_req, rst_req, q_fb,
    input  S, R, busy, done, last_op, err
  );

  modport slave (
    input  set_req, rst_req, q_fb,
    output S, R, busy, done, last_op, err
  );
endinterface

// File: rtl/sr_latch_drv.sv
// Drives the active-low S/R inputs of a NAND SR latch with fixed-width one-hot pulses.
// Optional Q read-back check is enabled by defining SR_LATCH_DRV_VERIFY_EN.
module sr_latch_drv #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input logic           clk,
  input logic           rst_n,
  sr_latch_drv_if.slave bus
);

  localparam logic [7:0] PULSE_LD = (PULSE_CYC < 1) ? 8'd1 : 8'(PULSE_CYC);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC);
  localparam bit         SKIP_GAP = (GAP_CYC == 0);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       s_p0;
  logic       r_p0;
  logic       busy_p0;
  logic       done_p0;
  logic       last_op_p0;
  logic       set_op;

  // Reset beats set when both are requested, so S is never pulled low in that case.
  assign set_op = bus.set_req & ~bus.rst_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_p0       <= 1'b1;
      r_p0       <= 1'b1;
      busy_p0    <= 1'b0;
      done_p0    <= 1'b0;
      last_op_p0 <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.set_req || bus.rst_req) begin
            state      <= PULSE;
            busy_p0    <= 1'b1;
            last_op_p0 <= set_op;
            s_p0       <= ~set_op;
            r_p0       <= set_op;
          end
        end
        PULSE: begin
          if (cnt <= 8'd1) begin
            s_p0 <= 1'b1;
            r_p0 <= 1'b1;
            if (SKIP_GAP) begin
              state   <= IDLE;
              busy_p0 <= 1'b0;
              done_p0 <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt <= 8'd1) begin
            state   <= IDLE;
            busy_p0 <= 1'b0;
            done_p0 <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          s_p0  <= 1'b1;
          r_p0  <= 1'b1;
        end
      endcase
    end
  end

  // Down-counter needs no reset: it is reloaded on every IDLE cycle before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:    cnt <= PULSE_LD;
      PULSE:   cnt <= (cnt <= 8'd1) ? GAP_LD : cnt - 8'd1;
      GAP:     cnt <= (cnt <= 8'd1) ? cnt : cnt - 8'd1;
      default: cnt <= PULSE_LD;
    endcase
  end

  assign bus.S       = s_p0;
  assign bus.R       = r_p0;
  assign bus.busy    = busy_p0;
  assign bus.done    = done_p0;
  assign bus.last_op = last_op_p0;

`ifdef SR_LATCH_DRV_VERIFY_EN
  logic chk_p1;
  logic err_p1;

  // chk_p1 marks the first cycle after the pulse, when Q must reflect the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      chk_p1 <= (state == PULSE) && (cnt <= 8'd1);
      if (chk_p1 && (bus.q_fb != last_op_p0)) begin
        err_p1 <= 1'b1;
      end
    end
  end

  assign bus.err = err_p1;
`else
  logic unused_q_fb;
  assign unused_q_fb = bus.q_fb;
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_drv.sv
// Bench for sr_latch_drv: two instances (2/1 and 0/0 pulse/gap) against a timing model
// derived from request acceptance times, plus directed literal expectations.
module tb_sr_latch_drv;

`ifdef SR_LATCH_DRV_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int P1 = 2;
  localparam int G1 = 1;
  localparam int P2 = 1;  // instance 2 is built with PULSE_CYC=0, which acts as 1
  localparam int G2 = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic bad = 1'b0;
  logic bad_val = 1'b0;
  logic lq1 = 1'b0;
  logic lq2 = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sr_latch_drv_if bus1();
  sr_latch_drv_if bus2();

  sr_latch_drv #(.PULSE_CYC(2), .GAP_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sr_latch_drv #(.PULSE_CYC(0), .GAP_CYC(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // NAND SR latch behaviour seen by each driver, with an override to inject a bad Q
  always @(bus1.S or bus1.R) begin
    if (!bus1.S) lq1 = 1'b1;
    else if (!bus1.R) lq1 = 1'b0;
  end
  always @(bus2.S or bus2.R) begin
    if (!bus2.S) lq2 = 1'b1;
    else if (!bus2.R) lq2 = 1'b0;
  end
  assign bus1.q_fb = bad ? bad_val : lq1;
  assign bus2.q_fb = bad ? bad_val : lq2;

  task automatic check(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_reqs(input logic s, input logic r);
    bus1.set_req = s;
    bus1.rst_req = r;
    bus2.set_req = s;
    bus2.rst_req = r;
  endtask

  // Model: an op is described only by the edge that accepted it and its kind
  typedef struct {
    int start;
    bit active;
    bit op;
    bit err;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input int e, input int p, input int g,
                                input bit rn, input bit sr, input bit rr, input bit q);
    mdl_t n;
    n = m;
    if (!rn) begin
      n.active = 1'b0;
      n.op     = 1'b0;
      n.err    = 1'b0;
      n.start  = 0;
      return n;
    end
    if (VERIFY && m.active && (e == m.start + p + 1) && (q != m.op)) n.err = 1'b1;
    if ((sr || rr) && (!m.active || (e >= m.start + p + g + 1))) begin
      n.active = 1'b1;
      n.start  = e;
      n.op     = sr && !rr;
    end
    return n;
  endfunction

  task automatic cmp_dut(input string tag, input mdl_t m, input int e, input int p, input int g,
                         input logic s, input logic r, input logic bsy, input logic dn,
                         input logic lo, input logic er);
    int d;
    bit low;
    d   = e - m.start;
    low = m.active && (d < p);
    check({tag, "_S"},    s,   !(low && m.op));
    check({tag, "_R"},    r,   !(low && !m.op));
    check({tag, "_busy"}, bsy, m.active && (d < p + g));
    check({tag, "_done"}, dn,  m.active && (d == p + g));
    check({tag, "_last"}, lo,  m.op);
    check({tag, "_err"},  er,  m.err);
    check({tag, "_inv"},  s | r, 1'b1);
  endtask

  // Per-cycle compare process: inputs sampled mid-low-phase, outputs 1 time unit after the edge
  initial begin
    mdl_t m1;
    mdl_t m2;
    int   e;
    bit   rn, sr, rr, q1, q2;
    m1 = '{start: 0, active: 1'b0, op: 1'b0, err: 1'b0};
    m2 = m1;
    e  = 0;
    forever begin
      @(negedge clk);
      #2;
      rn = rst_n;
      sr = bus1.set_req;
      rr = bus1.rst_req;
      q1 = bus1.q_fb;
      q2 = bus2.q_fb;
      @(posedge clk);
      e++;
      m1 = step(m1, e, P1, G1, rn, sr, rr, q1);
      m2 = step(m2, e, P2, G2, rn, sr, rr, q2);
      #1;
      cmp_dut("d1", m1, e, P1, G1, bus1.S, bus1.R, bus1.busy, bus1.done, bus1.last_op, bus1.err);
      cmp_dut("d2", m2, e, P2, G2, bus2.S, bus2.R, bus2.busy, bus2.done, bus2.last_op, bus2.err);
    end
  end

  initial begin
    int sc1, sc2, rc1, dc1, seen;
    rst_n = 1'b0;
    set_reqs(1'b0, 1'b0);

    // reset held with random requests
    repeat (5) begin
      @(negedge clk);
      set_reqs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rst_S", bus1.S, 1'b1);
      check("rst_R", bus1.R, 1'b1);
      check("rst_busy", bus1.busy, 1'b0);
      check("rst_done", bus1.done, 1'b0);
      check("rst_err", bus1.err, 1'b0);
      check("rst_S2", bus2.S, 1'b1);
      check("rst_R2", bus2.R, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_reqs(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // single set, accepted at edge 0
    set_reqs(1'b1, 1'b0);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    check("set_c1_S", bus1.S, 1'b0);
    check("set_c1_busy", bus1.busy, 1'b1);
    check("set_c1_last", bus1.last_op, 1'b1);
    check("set_c1_S2", bus2.S, 1'b0);
    @(negedge clk);
    check("set_c2_S", bus1.S, 1'b0);
    check("set_c2_R", bus1.R, 1'b1);
    check("set_c2_S2", bus2.S, 1'b1);
    check("set_c2_done2", bus2.done, 1'b1);
    @(negedge clk);
    check("set_c3_S", bus1.S, 1'b1);
    check("set_c3_busy", bus1.busy, 1'b1);
    check("set_c3_done", bus1.done, 1'b0);
    @(negedge clk);
    check("set_c4_done", bus1.done, 1'b1);
    check("set_c4_busy", bus1.busy, 1'b0);
    @(negedge clk);
    check("set_c5_done", bus1.done, 1'b0);
    repeat (3) @(negedge clk);

    // simultaneous set and reset
    set_reqs(1'b1, 1'b1);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    sc1 = 0; rc1 = 0; dc1 = 0;
    repeat (6) begin
      if (!bus1.S) sc1++;
      if (!bus1.R) rc1++;
      if (bus1.done) dc1++;
      @(negedge clk);
    end
    check_int("both_S_low", sc1, 0);
    check_int("both_R_low", rc1, 2);
    check_int("both_done", dc1, 1);
    check("both_last", bus1.last_op, 1'b0);
    repeat (2) @(negedge clk);

    // set_req held for 12 edges
    set_reqs(1'b1, 1'b0);
    sc1 = 0; sc2 = 0;
    repeat (12) begin
      @(negedge clk);
      if (!bus1.S) sc1++;
      if (!bus2.S) sc2++;
    end
    set_reqs(1'b0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if (!bus1.S) sc1++;
      if (!bus2.S) sc2++;
    end
    check_int("held_S_low1", sc1, 6);
    check_int("held_S_low2", sc2, 6);
    repeat (3) @(negedge clk);

    // async reset one cycle into an R pulse, then a fresh set
    set_reqs(1'b0, 1'b1);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    check("abort_pre_R", bus1.R, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_R", bus1.R, 1'b1);
    check("abort_S", bus1.S, 1'b1);
    check("abort_busy", bus1.busy, 1'b0);
    check("abort_R2", bus2.R, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    set_reqs(1'b1, 1'b0);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    seen = -1;
    for (int i = 1; i <= 8; i++) begin
      if (bus1.done && seen < 0) seen = i;
      @(negedge clk);
    end
    check_int("abort_then_set_done_cycle", seen, 4);
    check("abort_then_set_last", bus1.last_op, 1'b1);
    repeat (3) @(negedge clk);

    // set with Q stuck low
    bad = 1'b1;
    bad_val = 1'b0;
    set_reqs(1'b1, 1'b0);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("vfy_c3_err1", bus1.err, 1'b0);
    check("vfy_c3_err2", bus2.err, VERIFY);
    @(negedge clk);
    check("vfy_c4_err1", bus1.err, VERIFY);
    bad = 1'b0;
    repeat (2) @(negedge clk);
    set_reqs(1'b0, 1'b1);
    @(negedge clk);
    set_reqs(1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("vfy_sticky_err1", bus1.err, VERIFY);
    check("vfy_sticky_err2", bus2.err, VERIFY);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
